// File: rtl/axi_ad9963_adc_pack.sv
// AD9963 receive sample packer.
// Packs enabled 16-bit I/Q samples into 64-bit words (low lane first) and buffers
// them in a small FIFO towards the DMA write port.
//   adc_clk, adc_rst         : sample clock, asynchronous active-high reset
//   adc_enable_*/valid_*/data_* : per-channel enable, sample strobe and sample
//   pack_valid/pack_data/pack_sync/pack_ready : FIFO head word handshake; sync marks
//                                              the first word after reset/enable change
//   adc_dovf                 : one-cycle pulse per completed word dropped on overflow
module axi_ad9963_adc_pack #(
    parameter int unsigned FIFO_ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH      = 64
) (
    input  logic                  adc_clk,
    input  logic                  adc_rst,
    input  logic                  adc_enable_i,
    input  logic                  adc_valid_i,
    input  logic [15:0]           adc_data_i,
    input  logic                  adc_enable_q,
    input  logic                  adc_valid_q,
    input  logic [15:0]           adc_data_q,
    output logic                  pack_valid,
    output logic [DATA_WIDTH-1:0] pack_data,
    output logic                  pack_sync,
    input  logic                  pack_ready,
    output logic                  adc_dovf
);

    localparam int unsigned Depth = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] FullCount = (FIFO_ADDR_WIDTH + 1)'(Depth);

    // Packer state
    logic                  en_i_q, en_q_q;
    logic [1:0]            pos_q, pos_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  sync_pend_q, sync_pend_d;
    logic                  word_vld_q, word_vld_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  word_sync_q, word_sync_d;

    // FIFO state
    logic [DATA_WIDTH-1:0]      mem_q [Depth];
    logic                       sync_mem_q [Depth];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;

    logic en_change, dual, single_i, single_q, beat;
    logic [5:0] lane0, lane1;
    logic fifo_full, push, pop;

    always_comb begin
        en_change = (adc_enable_i != en_i_q) | (adc_enable_q != en_q_q);
        dual      = en_i_q & en_q_q;
        single_i  = en_i_q & ~en_q_q;
        single_q  = ~en_i_q & en_q_q;
        // Beats in an enable-change cycle are dropped along with the partial word.
        beat      = ~en_change & (((dual | single_i) & adc_valid_i) | (single_q & adc_valid_q));
        lane0     = {pos_q, 4'b0000};
        lane1     = {pos_q + 2'd1, 4'b0000};

        pos_d       = pos_q;
        acc_d       = acc_q;
        sync_pend_d = sync_pend_q;
        word_vld_d  = 1'b0;
        word_d      = word_q;
        word_sync_d = word_sync_q;

        if (en_change) begin
            pos_d       = 2'd0;
            sync_pend_d = 1'b1;
        end else if (beat) begin
            if (dual) begin
                acc_d[lane0 +: 16] = adc_data_i;
                acc_d[lane1 +: 16] = adc_data_q;
                pos_d              = pos_q + 2'd2;
            end else begin
                acc_d[lane0 +: 16] = single_q ? adc_data_q : adc_data_i;
                pos_d              = pos_q + 2'd1;
            end
            // Counter wrapping to 0 marks the completing beat.
            if (pos_d == 2'd0) begin
                word_vld_d  = 1'b1;
                word_d      = acc_d;
                word_sync_d = sync_pend_q;
                sync_pend_d = 1'b0;
            end
        end
    end

    always_comb begin
        fifo_full  = (count_q == FullCount);
        pack_valid = (count_q != '0);
        pack_data  = mem_q[rd_ptr_q];
        pack_sync  = sync_mem_q[rd_ptr_q];
        pop        = pack_valid & pack_ready;
        // A simultaneous pop frees the slot, so a full FIFO can still accept.
        push       = word_vld_q & (~fifo_full | pop);
        adc_dovf   = word_vld_q & fifo_full & ~pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            en_i_q      <= 1'b0;
            en_q_q      <= 1'b0;
            pos_q       <= 2'd0;
            acc_q       <= '0;
            sync_pend_q <= 1'b1;
            word_vld_q  <= 1'b0;
            word_q      <= '0;
            word_sync_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i]      <= '0;
                sync_mem_q[i] <= 1'b0;
            end
        end else begin
            en_i_q      <= adc_enable_i;
            en_q_q      <= adc_enable_q;
            pos_q       <= pos_d;
            acc_q       <= acc_d;
            sync_pend_q <= sync_pend_d;
            word_vld_q  <= word_vld_d;
            word_q      <= word_d;
            word_sync_q <= word_sync_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push) begin
                mem_q[wr_ptr_q]      <= word_q;
                sync_mem_q[wr_ptr_q] <= word_sync_q;
            end
        end
    end

endmodule
